minicpu_sequencer: RTL and testbench

//  Program sequencer for the MiniCPU datapath. Holds a small program of 12-bit

---
 rtl/minicpu_pkg.sv | 17 +
 rtl/seq_prog_mem.sv | 19 +
 rtl/minicpu_sequencer.sv | 132 +++++++++++++
 tb/tb_minicpu_sequencer.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/minicpu_pkg.sv
// minicpu_pkg: shared MiniCPU instruction constants and sequencer state encoding
package minicpu_pkg;
    localparam int IW = 12;
    localparam int RW = 8;
    localparam int OP_MSB = 11;
    localparam int OP_LSB = 8;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LOAD = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [IW-1:0] NOP_INSTR = 12'h000;
    typedef enum logic [2:0] {ST_IDLE, ST_ISSUE, ST_HOLD, ST_SAMPLE, ST_FIN} state_t;
endpackage

// File: rtl/seq_prog_mem.sv
// seq_prog_mem: program store, one synchronous write port and one asynchronous read port
module seq_prog_mem #(
    parameter int IW    = 12,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [IW-1:0] rd_data
);
    logic [IW-1:0] mem_q [DEPTH];
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_addr] <= wr_data;
    end
    assign rd_data = mem_q[rd_addr];
endmodule

// File: rtl/minicpu_sequencer.sv
// minicpu_sequencer: issues a stored program to MiniCPU one instruction at a time and captures results
module minicpu_sequencer #(
    parameter int IW     = minicpu_pkg::IW,
    parameter int RW     = minicpu_pkg::RW,
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int SETTLE = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [IW-1:0] wr_data,
    input  logic          start,
    input  logic [AW:0]   len,
    input  logic          halt_on_ovf,
    output logic [IW-1:0] cpu_in,
    input  logic [RW-1:0] cpu_result,
    input  logic          cpu_overflow,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pc,
    output logic [RW-1:0] last_result,
    output logic          ovf_flag,
    output logic [AW-1:0] ovf_pc
);
    import minicpu_pkg::*;
    localparam int CW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    state_t        state_q, state_d;
    logic [IW-1:0] cpu_in_q, cpu_in_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [AW-1:0] ovf_pc_q, ovf_pc_d;
    logic [RW-1:0] last_q, last_d;
    logic          ovf_q, ovf_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW:0]   len_q, len_d;
    logic          halt_q, halt_d;
    logic [IW-1:0] rd_data;
    logic          last_instr;
    seq_prog_mem #(.IW(IW), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .wr_en   (wr_en && !busy),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (pc_q),
        .rd_data (rd_data)
    );
    assign last_instr = {1'b0, pc_q} == len_q - (AW+1)'(1);
    always_comb begin
        state_d  = state_q;
        cpu_in_d = cpu_in_q;
        pc_d     = pc_q;
        ovf_pc_d = ovf_pc_q;
        last_d   = last_q;
        ovf_d    = ovf_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        halt_d   = halt_q;
        case (state_q)
            ST_IDLE: begin
                if (start && len == '0) begin
                    state_d = ST_FIN;
                end else if (start) begin
                    state_d  = ST_ISSUE;
                    len_d    = len > DEPTH_L ? DEPTH_L : len;
                    halt_d   = halt_on_ovf;
                    ovf_d    = 1'b0;
                    ovf_pc_d = '0;
                    pc_d     = '0;
                end
            end
            ST_ISSUE: begin
                cpu_in_d = rd_data;
                cnt_d    = CW'(SETTLE - 1);
                state_d  = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = cnt_q == '0 ? ST_SAMPLE : ST_HOLD;
                cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - CW'(1);
            end
            ST_SAMPLE: begin
                last_d = cpu_result;
                if (cpu_overflow && !ovf_q) begin
                    ovf_d    = 1'b1;
                    ovf_pc_d = pc_q;
                end
                if ((cpu_overflow && halt_q) || last_instr) begin
                    state_d = ST_FIN;
                end else begin
                    pc_d    = pc_q + AW'(1);
                    state_d = ST_ISSUE;
                end
            end
            ST_FIN: begin
                cpu_in_d = NOP_INSTR;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cpu_in_q <= '0;
            pc_q     <= '0;
            ovf_pc_q <= '0;
            last_q   <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cpu_in_q <= cpu_in_d;
            pc_q     <= pc_d;
            ovf_pc_q <= ovf_pc_d;
            last_q   <= last_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            halt_q   <= halt_d;
        end
    end
    assign busy        = state_q == ST_ISSUE || state_q == ST_HOLD || state_q == ST_SAMPLE;
    assign done        = state_q == ST_FIN;
    assign cpu_in      = cpu_in_q;
    assign pc          = pc_q;
    assign last_result = last_q;
    assign ovf_flag    = ovf_q;
    assign ovf_pc      = ovf_pc_q;
endmodule

// File: tb/tb_minicpu_sequencer.sv
// tb_minicpu_sequencer: directed run vectors against a toy MiniCPU model plus multi-cycle corner sequences
module tb_minicpu_sequencer;
    logic        clk = 1'b0;
    logic        rst_n, wr_en, start, halt_on_ovf, cpu_overflow;
    logic [3:0]  wr_addr;
    logic [11:0] wr_data, cpu_in;
    logic [4:0]  len;
    logic [7:0]  cpu_result, last_result;
    logic        busy, done, ovf_flag;
    logic [3:0]  pc, ovf_pc;

    typedef struct {
        logic [4:0] len;
        logic       halt;
        int         cyc;
        int         n_iss;
        logic [7:0] last;
        logic       flag;
        logic [3:0] opc;
        logic [3:0] pc;
    } vec_t;

    vec_t        tbl[8];
    logic [11:0] prog[16];
    logic [11:0] iss[$];
    int          cyc, nvec = 0, nfail = 0;

    always #5 clk = ~clk;

    // Toy datapath: result is the low byte plus one, opcode F reports overflow.
    assign cpu_result   = cpu_in[7:0] + 8'd1;
    assign cpu_overflow = cpu_in[11:8] == 4'hF;

    minicpu_sequencer dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .len(len), .halt_on_ovf(halt_on_ovf), .cpu_in(cpu_in),
        .cpu_result(cpu_result), .cpu_overflow(cpu_overflow), .busy(busy), .done(done),
        .pc(pc), .last_result(last_result), .ovf_flag(ovf_flag), .ovf_pc(ovf_pc)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_cpu_in"}, 32'(cpu_in), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_pc"}, 32'(pc), 0);
        chk({tag, "_last"}, 32'(last_result), 0);
        chk({tag, "_flag"}, 32'(ovf_flag), 0);
        chk({tag, "_ovf_pc"}, 32'(ovf_pc), 0);
    endtask

    task automatic write_mem(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // mode 1: write during run, mode 2: start during run, mode 3: write together with start
    task automatic do_run(input logic [4:0] l, input logic h, input int mode);
        logic [11:0] prev;
        @(negedge clk);
        start = 1'b1; len = l; halt_on_ovf = h;
        if (mode == 3) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 12'h042;
        end
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0;
        cyc = 1;
        iss.delete();
        prev = cpu_in;
        while (!done && cyc < 200) begin
            if (cpu_in !== prev) begin
                iss.push_back(cpu_in);
                prev = cpu_in;
            end
            chk("busy_in_run", 32'(busy), 1);
            wr_en = mode == 1 && cyc == 2; wr_addr = 4'd0; wr_data = 12'hFFF;
            start = mode == 2 && cyc == 2; len = 5'd4;
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0; start = 1'b0;
        chk("done_seen", 32'(done), 1);
    endtask

    task automatic post_run(input string tag);
        @(negedge clk);
        chk({tag, "_cpu_in_after"}, 32'(cpu_in), 0);
        chk({tag, "_busy_after"}, 32'(busy), 0);
        chk({tag, "_done_after"}, 32'(done), 0);
    endtask

    initial begin
        int nd;
        rst_n = 1'b0; wr_en = 1'b0; start = 1'b0; halt_on_ovf = 1'b0;
        wr_addr = '0; wr_data = '0; len = '0;
        for (int i = 0; i < 16; i++) prog[i] = {(i == 1 || i == 5) ? 4'hF : 4'h1, 8'(i * 17)};
        //            len   halt cyc n_iss last   flag opc pc
        tbl[0] = '{5'd4,  1'b0, 17, 4,  8'd52, 1'b1, 4'd1, 4'd3};
        tbl[1] = '{5'd4,  1'b1, 9,  2,  8'd18, 1'b1, 4'd1, 4'd1};
        tbl[2] = '{5'd1,  1'b1, 5,  1,  8'd1,  1'b0, 4'd0, 4'd0};
        tbl[3] = '{5'd0,  1'b0, 1,  0,  8'd1,  1'b0, 4'd0, 4'd0};
        tbl[4] = '{5'd20, 1'b0, 65, 16, 8'd0,  1'b1, 4'd1, 4'd15};
        tbl[5] = '{5'd3,  1'b0, 13, 3,  8'd35, 1'b1, 4'd1, 4'd2};
        tbl[6] = '{5'd16, 1'b1, 9,  2,  8'd18, 1'b1, 4'd1, 4'd1};
        tbl[7] = '{5'd6,  1'b0, 25, 6,  8'd86, 1'b1, 4'd1, 4'd5};
        repeat (2) @(negedge clk);
        chk_idle_outputs("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) write_mem(4'(i), prog[i]);

        for (int i = 0; i < 8; i++) begin
            do_run(tbl[i].len, tbl[i].halt, 0);
            chk($sformatf("v%0d_cycles", i), 32'(cyc), 32'(tbl[i].cyc));
            chk($sformatf("v%0d_n_issued", i), 32'(iss.size()), 32'(tbl[i].n_iss));
            for (int k = 0; k < iss.size() && k < tbl[i].n_iss; k++)
                chk($sformatf("v%0d_issued%0d", i, k), 32'(iss[k]), 32'(prog[k]));
            chk($sformatf("v%0d_last", i), 32'(last_result), 32'(tbl[i].last));
            chk($sformatf("v%0d_flag", i), 32'(ovf_flag), 32'(tbl[i].flag));
            chk($sformatf("v%0d_ovf_pc", i), 32'(ovf_pc), 32'(tbl[i].opc));
            chk($sformatf("v%0d_pc", i), 32'(pc), 32'(tbl[i].pc));
            post_run($sformatf("v%0d", i));
        end

        // Reset while holding the first instruction of a 3-instruction run.
        @(negedge clk);
        start = 1'b1; len = 5'd3; halt_on_ovf = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1 chk_idle_outputs("midrun_reset");
        @(negedge clk);
        rst_n = 1'b1;
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) nd++;
        end
        chk("midrun_reset_no_activity", 32'(nd), 0);

        // Write while busy is dropped.
        do_run(5'd1, 1'b0, 1);
        chk("wr_busy_cycles", 32'(cyc), 5);
        post_run("wr_busy");
        do_run(5'd1, 1'b0, 0);
        chk("wr_busy_n_issued", 32'(iss.size()), 1);
        if (iss.size() > 0) chk("wr_busy_mem0", 32'(iss[0]), 32'(prog[0]));
        chk("wr_busy_last", 32'(last_result), 1);
        post_run("wr_busy2");

        // Start while busy is ignored.
        do_run(5'd2, 1'b0, 2);
        chk("start_busy_cycles", 32'(cyc), 9);
        chk("start_busy_pc", 32'(pc), 1);
        post_run("start_busy");
        nd = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) nd++;
        end
        chk("start_busy_extra_done", 32'(nd), 0);

        // Write on the start edge is visible to the first issue.
        do_run(5'd1, 1'b0, 3);
        chk("wr_start_n_issued", 32'(iss.size()), 1);
        if (iss.size() > 0) chk("wr_start_mem0", 32'(iss[0]), 32'h042);
        chk("wr_start_last", 32'(last_result), 32'h43);
        post_run("wr_start");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule
